// File: rtl/bundle_decoder.sv
// bundle_decoder: consumer end of the fetch interface.
// Buffers 60-bit fetch bundles (two 30-bit instructions, upper slot first)
// in a small FIFO and hands out one decoded instruction per cycle over a
// valid/ready handshake. full_o holds the PC while no space is available.
// Optional feature macro: BUNDLE_DECODER_NOP_SQUASH_EN. When defined,
// opcode-0 slots are never presented and all-NOP bundles are not stored.
module bundle_decoder #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [59:0] data_i,
  input  logic        enable_i,
  input  logic        flush_i,
  output logic        full_o,
  output logic        overflow_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        slot_o,
  output logic        format_o,
  output logic        branch_o,
  output logic [6:0]  opcode_o,
  output logic [4:0]  primary_o,
  output logic [4:0]  secondary_o,
  output logic [15:0] immediate_o
);

  // Storage: bundle plus a per-slot live mask (bit 0 = upper slot).
  logic [59:0] bundle_mem [DEPTH];
  logic [1:0]  mask_mem   [DEPTH];

  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W:0]   count_reg, count_next;
  logic             slot_reg, slot_next;
  logic             overflow_reg, overflow_next;

  logic             write_en;
  logic [PTR_W-1:0] write_addr;

  logic [59:0] head_bundle;
  logic [1:0]  head_mask;
  logic        cur_slot;
  logic [29:0] cur_instr;
  logic        not_empty;
  logic        full;
  logic        valid;
  logic        xfer;
  logic        advance;
  logic        pop;
  logic [1:0]  push_mask;
  logic        push_req;
  logic        push_ok;

`ifdef BUNDLE_DECODER_NOP_SQUASH_EN
  // A slot is live only when its opcode field is non-zero.
  for (genvar gi = 0; gi < 2; gi++) begin : g_live
    assign push_mask[gi] = |data_i[(1-gi)*30 + 21 +: 7];
  end
`else
  assign push_mask = 2'b11;
`endif

  assign push_req = enable_i & (|push_mask);

  // Head entry view; slot pointer skips a dead upper slot on its own so a
  // freshly pushed or popped-to head needs no extra bookkeeping.
  assign head_bundle = bundle_mem[rd_ptr_reg];
  assign head_mask   = mask_mem[rd_ptr_reg];
  assign not_empty   = (count_reg != '0);
  assign full        = (count_reg == (PTR_W+1)'(DEPTH));
  assign cur_slot    = slot_reg | ~head_mask[0];
  assign valid       = not_empty & head_mask[cur_slot];
  assign cur_instr   = cur_slot ? head_bundle[29:0] : head_bundle[59:30];

  assign xfer    = valid & ready_i;
  assign advance = xfer & ~cur_slot & head_mask[1];
  assign pop     = xfer & ~advance;
  assign push_ok = push_req & (~full | pop);

  // Field decode: all-zero when nothing is being presented.
  always_comb begin
    slot_o      = 1'b0;
    format_o    = 1'b0;
    branch_o    = 1'b0;
    opcode_o    = '0;
    primary_o   = '0;
    secondary_o = '0;
    immediate_o = '0;
    if (valid) begin
      slot_o      = cur_slot;
      format_o    = cur_instr[29];
      branch_o    = cur_instr[28];
      opcode_o    = cur_instr[27:21];
      primary_o   = cur_instr[20:16];
      secondary_o = cur_instr[15:11];
      immediate_o = cur_instr[15:0];
    end
  end

  assign valid_o    = valid;
  assign full_o     = full;
  assign overflow_o = overflow_reg;

  // Next-state: flush wins over consume; a push alongside flush lands in slot 0.
  always_comb begin
    rd_ptr_next   = rd_ptr_reg;
    wr_ptr_next   = wr_ptr_reg;
    count_next    = count_reg;
    slot_next     = slot_reg;
    overflow_next = overflow_reg;
    write_en      = 1'b0;
    write_addr    = wr_ptr_reg;
    if (flush_i) begin
      rd_ptr_next = '0;
      slot_next   = 1'b0;
      write_addr  = '0;
      write_en    = push_req;
      wr_ptr_next = push_req ? PTR_W'(1) : '0;
      count_next  = push_req ? (PTR_W+1)'(1) : '0;
    end else begin
      if (advance) begin
        slot_next = 1'b1;
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        slot_next   = 1'b0;
      end
      if (push_ok) begin
        write_en    = 1'b1;
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (push_req & full & ~pop) begin
        overflow_next = 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count_next = count_reg + (PTR_W+1)'(1);
        2'b01:   count_next = count_reg - (PTR_W+1)'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  // Control state register with asynchronous active-low reset.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
      slot_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
      slot_reg     <= slot_next;
      overflow_reg <= overflow_next;
    end
  end

  // Bundle storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clock_i) begin
    if (write_en) begin
      bundle_mem[write_addr] <= data_i;
      mask_mem[write_addr]   <= push_mask;
    end
  end

endmodule

// File: doc/bundle_decoder.md
Name: bundle_decoder

Overview:
- Consumer end of the fetch interface: accepts 60-bit fetch bundles (two 30-bit instructions, upper slot first) qualified by a one-cycle enable pulse.
- Buffers bundles in a small FIFO and splits each into per-instruction fields.
- Presents one instruction per cycle to issue via a valid/ready handshake.
- Drives full_o back to PC logic so that PC is held while no space is available.

Parameters:
- DEPTH, 4, bundle FIFO entries (power of two, >=2)
- PTR_W, 2, log2(DEPTH)

Ports:
- clock_i  in  1  rising-edge clock
- reset_i  in  1  asynchronous, active-low reset
- data_i  in  60  fetch bundle; [59:30] = slot 0, [29:0] = slot 1
- enable_i  in  1  bundle valid this cycle (single-cycle pulse per bundle)
- flush_i  in  1  branch redirect; discard all buffered work
- full_o  out  1  FIFO holds DEPTH bundles (combinational from count)
- overflow_o  out  1  sticky: bundle arrived while full and was dropped
- valid_o  out  1  instruction fields valid
- ready_i  in  1  issue accepts instruction
- slot_o  out  1  0 = upper instruction, 1 = lower
- format_o  out  1  instr[29]; 1 = reg-immediate, 0 = reg-reg
- branch_o  out  1  instr[28]
- opcode_o  out  7  instr[27:21]
- primary_o  out  5  instr[20:16]
- secondary_o  out  5  instr[15:11]
- immediate_o  out  16  instr[15:0]

Behaviour:
- Reset (reset_i=0, async):
  - count=0, pointers=0, slot=0, overflow_o=0.
  - valid_o=0, full_o=0; all field outputs 0.
- Storage:
  - Each FIFO entry holds the 60-bit bundle plus a 2-bit live mask.
  - Fields are decoded combinationally from the head entry and the current slot.
  - valid_o=1 when count>0 and the head has a live slot at or after the slot pointer.
  - When valid_o=0, all field outputs are 0.
- Latency:
  - A bundle sampled with enable_i=1 at edge N is visible on outputs after edge N when the FIFO was empty.
  - This is a one-cycle latency.
- Consume:
  - A transfer occurs at an edge where valid_o=1 and ready_i=1.
  - If a later live slot remains in the head entry, slot advances to it.
  - Otherwise the head pops (read pointer +1 mod DEPTH, wrap-around) and slot resets to the first live slot of the new head.
- Push:
  - Occurs at an edge with enable_i=1, written at the write pointer (+1 mod DEPTH).
  - If full_o=1, the push is accepted only when a pop occurs in the same cycle; count is then unchanged.
  - Otherwise the bundle is dropped and overflow_o is set to 1, held until reset.
- Simultaneous push and pop when not full: count unchanged, both pointers advance.
- Flush:
  - Has priority over consume.
  - Sets count=0, pointers=0, slot=0; overflow_o is unaffected.
  - enable_i in the same cycle as flush_i: the bundle is written into the emptied FIFO (count=1), because it is the redirect target.
- Zero-width values: opcode 0 with format 0 (all-zero slot) is passed through as a normal instruction unless the optional feature is enabled.
- No back-pressure on data_i: upstream must honour full_o.

Optional Feature:
- Macro: BUNDLE_DECODER_NOP_SQUASH_EN.
- Defined:
  - A slot with opcode_o==0 (any format) is marked not live at push.
  - Non-live slots are never presented.
  - A bundle with both slots NOP is not written: count, pointers and overflow_o are unchanged, even when full.
- Undefined: live mask is always 2'b11; every slot is presented.

Test Plan:
1. Reset, then push 60'b1_0_0000100_00001_0000000000001010__1_0_0000100_00010_0000000000000101 with ready_i=1.
   - Next cycle: valid_o=1, slot_o=0, format_o=1, opcode_o=4, primary_o=1, immediate_o=10.
   - Following cycle: slot_o=1, primary_o=2, immediate_o=5.
   - Then valid_o=0.
2. ready_i=0, push 4 bundles: full_o=1 after the 4th. A 5th push sets overflow_o=1 and stored contents are unchanged. Release ready_i: 8 instructions appear in order, then valid_o=0.
3. Full FIFO with head slot 1 being consumed while enable_i=1: pop and push in the same edge, count stays 4, overflow_o stays 0.
4. 3 bundles buffered, flush_i=1 together with enable_i=1 carrying bundle X: next cycle count=1 and the X slot 0 fields are presented.
5. Assert reset_i=0 mid-stream between edges: valid_o, full_o and overflow_o drop to 0 immediately, without waiting for a clock edge.
6. With NOP_SQUASH_EN, push 60'b0_0_0000001_00001_00010_00000000000__000000000000000000000000000000: one instruction is presented (opcode_o=1, primary_o=1, secondary_o=2), then valid_o=0. Pushing an all-NOP bundle leaves count=0.
